lieat_exu_vpu_vseq16: RTL and testbench
=======================================

Name: lieat_exu_vpu_vseq16

Overview:
- Element sequencer (issuing side) for the 16-bit vector lane unit in the VPU execute stage.
- Accepts one vector add/sub/rsub operation over whole registers through a valid/ready handshake.
- Drives the lane unit one 16-bit element per cycle, collects the lane results in order, and returns the assembled destination vector with a valid/ready handshake.
- Tail elements (index >= vl) pass through from the old destination value unchanged.

Parameters:
- VLEN, 128, vector register width in bits; must be a multiple of 16.
- NELEM, VLEN/16, element count (derived; do not override).
- VLW, $clog2(NELEM)+1, width of the vl input and element counters (derived).

Ports:
- clock  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- i_valid  input  1  operation request
- i_ready  output  1  sequencer can accept an operation
- i_vadd  input  1  op select: add
- i_vsub  input  1  op select: vs1-vs2
- i_vrsub  input  1  op select: vs2-vs1
- i_vs1  input  VLEN  source vector 1; element k = bits [16k+15:16k]
- i_vs2  input  VLEN  source vector 2
- i_vd  input  VLEN  old destination value, used for tail elements
- i_vl  input  VLW  active element count
- vunit_valid  output  1  element issue to the lane unit
- vunit_op1  output  16  element of vs1
- vunit_op2  output  16  element of vs2
- vunit_vadd / vunit_vsub / vunit_vrsub  output  1 each  latched op selects
- vunit_o_valid  input  1  lane result valid (results return in order)
- vunit_o_data  input  16  lane result
- o_valid  output  1  result vector valid
- o_ready  input  1  downstream accepts the result
- o_data  output  VLEN  assembled destination vector

Behaviour:
- Reset (asynchronous, active-high): all state clears immediately.
  - FSM = IDLE; counters = 0; result register = 0; latched op = 0.
  - Output values during and after reset: i_ready=1, vunit_valid=0, vunit_op*=0, vunit_v*=0, o_valid=0, o_data=0.
  - Reset mid-operation discards the operation in flight. No result is produced, and late vunit_o_valid pulses after reset are ignored because the counters are 0 and the FSM is in IDLE.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - i_ready=1.
  - On i_valid at edge T, latch vs1, vs2, the op selects, and vl_eff = min(i_vl, NELEM).
  - Load the result register with i_vd.
  - Clear issue_cnt and col_cnt.
  - Next state is ISSUE if vl_eff>0, otherwise DONE.
- i_ready=0 in every state other than IDLE; back-to-back operations are not overlapped.
- ISSUE:
  - vunit_valid=1; vunit_op1/op2 = element issue_cnt of the latched vs1/vs2.
  - vunit_v* are driven from the latched op in ISSUE and DRAIN, and are 0 otherwise.
  - issue_cnt increments each cycle.
  - When issue_cnt reaches vl_eff-1 on an issuing cycle, go to DRAIN. If the same cycle also collects the final result, go directly to DONE.
- Collection (ISSUE or DRAIN only):
  - A vunit_o_valid pulse with col_cnt < issued_count writes vunit_o_data into result element col_cnt, then col_cnt increments.
  - issued_count includes the element issued in the same cycle, so a combinational lane result is captured the same cycle.
  - vunit_o_valid in any other case (IDLE, DONE, or no outstanding element) is ignored.
- DRAIN: vunit_valid=0; wait until col_cnt == vl_eff, then go to DONE.
- DONE:
  - o_valid=1 and o_data = result register; o_data is stable while o_valid=1.
  - On o_ready, go to IDLE; o_valid drops the next cycle.
  - o_valid with o_ready low holds indefinitely.
- Latency with the combinational lane unit (accept at edge T):
  - Element k is issued in cycle T+1+k.
  - o_valid is asserted from cycle T+1+vl_eff.
  - vl=0 gives o_valid at T+1 with o_data = i_vd.
- Arithmetic: the sequencer does no arithmetic. Results are modulo 2^16 as produced by the lane unit.
  - Zero-hot op selects are forwarded as-is; the lane returns 0, so active elements become 0.
  - Multi-hot op selects are forwarded unchanged; this is the caller's responsibility.
- Tail elements (k >= vl_eff) keep their i_vd value.
- i_vl > NELEM is clamped to NELEM.

Decomposition:
- Shared VPU package:
  - ELEN=16 and the VLEN default.
  - FSM state enum {IDLE, ISSUE, DRAIN, DONE}.
  - Packed op-select struct {vadd, vsub, vrsub}.
- Element slice/insert helper functions also belong in the package.
- No sub-module is needed. The lane unit is instantiated alongside the sequencer by the parent, not inside it.

Test Plan:
- Reset release, then vadd with VLEN=128, vl=8, vs1 elements = k+1, vs2 elements = 0x0010 -> vunit_valid for 8 consecutive cycles; o_valid at T+9; element k = 0x0011+k.
- vsub with vl=3, vs1 all 0x0000, vs2 all 0x0001, vd all 0xAAAA -> elements 0..2 = 0xFFFF (wrap), elements 3..7 = 0xAAAA; i_ready=0 throughout.
- vrsub with vl=0, vd = 0x0123...CDEF pattern -> no vunit_valid pulse; o_valid at T+1; o_data equals vd.
- vl=15 (clamped) vadd with o_ready held low for 5 cycles after o_valid -> exactly 8 issues; o_data stable for 5 cycles; i_ready reasserts the cycle after o_ready.
- Lane model delaying each result by 2 cycles, vl=4 -> DRAIN entered after 4 issues; results land in order; o_valid once col_cnt=4.
- Reset asserted asynchronously at issue_cnt=2, stray vunit_o_valid afterward -> outputs immediately at reset values; next operation completes with correct data.

Source files
------------

// File: rtl/lieat_exu_vpu_vseq16_pkg.sv
// Shared VPU definitions for the 16-bit element sequencer: element width, FSM states,
// op-select payload and element slice/insert helpers.
package lieat_exu_vpu_vseq16_pkg;

  localparam int unsigned ELEN     = 16;
  localparam int unsigned VLEN_DEF = 128;
  // Helpers operate on a padded vector so they serve any VLEN up to this bound
  localparam int unsigned VLEN_MAX = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vseq_state_e;

  typedef struct packed {
    logic vadd;
    logic vsub;
    logic vrsub;
  } vop_sel_t;

  function automatic logic [ELEN-1:0] elem_get(input logic [VLEN_MAX-1:0] vec,
                                               input int unsigned       k);
    return vec[k*ELEN +: ELEN];
  endfunction

  function automatic logic [VLEN_MAX-1:0] elem_put(input logic [VLEN_MAX-1:0] vec,
                                                   input int unsigned       k,
                                                   input logic [ELEN-1:0]   elem);
    logic [VLEN_MAX-1:0] res;
    res = vec;
    res[k*ELEN +: ELEN] = elem;
    return res;
  endfunction

endpackage

// File: rtl/lieat_exu_vpu_vseq16.sv
// Issuing-side element sequencer: feeds the 16-bit lane unit one element per cycle and
// reassembles the in-order lane results into the destination vector (tail kept from vd).
module lieat_exu_vpu_vseq16
  import lieat_exu_vpu_vseq16_pkg::*;
#(
  parameter int unsigned  VLEN  = VLEN_DEF,
  localparam int unsigned NELEM = VLEN / ELEN,
  localparam int unsigned VLW   = $clog2(NELEM) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic            i_vadd,
  input  logic            i_vsub,
  input  logic            i_vrsub,
  input  logic [VLEN-1:0] i_vs1,
  input  logic [VLEN-1:0] i_vs2,
  input  logic [VLEN-1:0] i_vd,
  input  logic [VLW-1:0]  i_vl,
  output logic            vunit_valid,
  output logic [ELEN-1:0] vunit_op1,
  output logic [ELEN-1:0] vunit_op2,
  output logic            vunit_vadd,
  output logic            vunit_vsub,
  output logic            vunit_vrsub,
  input  logic            vunit_o_valid,
  input  logic [ELEN-1:0] vunit_o_data,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [VLEN-1:0] o_data
);

  vseq_state_e     state_q, state_d;
  logic [VLW-1:0]  issue_cnt_q, issue_cnt_d;
  logic [VLW-1:0]  col_cnt_q, col_cnt_d;
  logic [VLW-1:0]  vl_q, vl_d;
  logic [VLW-1:0]  vl_eff;
  logic [VLW-1:0]  issued_cnt;
  logic [VLEN-1:0] vs1_q, vs1_d;
  logic [VLEN-1:0] vs2_q, vs2_d;
  logic [VLEN-1:0] res_q, res_d;
  vop_sel_t        op_q, op_d;
  logic            collect;

  // Next-state, counters and result assembly
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    col_cnt_d   = col_cnt_q;
    vl_d        = vl_q;
    vs1_d       = vs1_q;
    vs2_d       = vs2_q;
    res_d       = res_q;
    op_d        = op_q;

    vl_eff     = (i_vl > VLW'(NELEM)) ? VLW'(NELEM) : i_vl;
    // Count the element going out this cycle so a combinational lane is caught same-cycle
    issued_cnt = issue_cnt_q + ((state_q == ISSUE) ? VLW'(1) : VLW'(0));
    collect    = ((state_q == ISSUE) || (state_q == DRAIN)) && vunit_o_valid &&
                 (col_cnt_q < issued_cnt);

    if (collect) begin
      res_d     = VLEN'(elem_put(VLEN_MAX'(res_q), 32'(col_cnt_q), vunit_o_data));
      col_cnt_d = col_cnt_q + VLW'(1);
    end

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          vs1_d       = i_vs1;
          vs2_d       = i_vs2;
          op_d        = '{vadd: i_vadd, vsub: i_vsub, vrsub: i_vrsub};
          vl_d        = vl_eff;
          res_d       = i_vd;
          issue_cnt_d = '0;
          col_cnt_d   = '0;
          state_d     = (vl_eff != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        issue_cnt_d = issue_cnt_q + VLW'(1);
        if (issue_cnt_q == vl_q - VLW'(1)) begin
          state_d = (col_cnt_d == vl_q) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (col_cnt_d == vl_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (o_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    i_ready     = (state_q == IDLE);
    vunit_valid = (state_q == ISSUE);
    vunit_op1   = '0;
    vunit_op2   = '0;
    vunit_vadd  = 1'b0;
    vunit_vsub  = 1'b0;
    vunit_vrsub = 1'b0;
    o_valid     = (state_q == DONE);
    o_data      = res_q;
    if (state_q == ISSUE) begin
      vunit_op1 = elem_get(VLEN_MAX'(vs1_q), 32'(issue_cnt_q));
      vunit_op2 = elem_get(VLEN_MAX'(vs2_q), 32'(issue_cnt_q));
    end
    if ((state_q == ISSUE) || (state_q == DRAIN)) begin
      vunit_vadd  = op_q.vadd;
      vunit_vsub  = op_q.vsub;
      vunit_vrsub = op_q.vrsub;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      col_cnt_q   <= '0;
      vl_q        <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      res_q       <= '0;
      op_q        <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      col_cnt_q   <= col_cnt_d;
      vl_q        <= vl_d;
      vs1_q       <= vs1_d;
      vs2_q       <= vs2_d;
      res_q       <= res_d;
      op_q        <= op_d;
    end
  end

endmodule

// File: tb/tb_lieat_exu_vpu_vseq16.sv
// Self-checking bench for the vector element sequencer with a behavioural lane unit
// (combinational or 2-cycle delayed) and a whole-vector reference model.
module tb_lieat_exu_vpu_vseq16;

  localparam int unsigned VLEN  = 128;
  localparam int unsigned NELEM = VLEN / 16;
  localparam int unsigned VLW   = $clog2(NELEM) + 1;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            i_valid = 1'b0;
  logic            i_ready;
  logic            i_vadd = 1'b0, i_vsub = 1'b0, i_vrsub = 1'b0;
  logic [VLEN-1:0] i_vs1 = '0, i_vs2 = '0, i_vd = '0;
  logic [VLW-1:0]  i_vl = '0;
  logic            vunit_valid;
  logic [15:0]     vunit_op1, vunit_op2;
  logic            vunit_vadd, vunit_vsub, vunit_vrsub;
  logic            vunit_o_valid;
  logic [15:0]     vunit_o_data;
  logic            o_valid;
  logic            o_ready = 1'b0;
  logic [VLEN-1:0] o_data;

  int   checks = 0;
  int   errors = 0;
  int   lane_delay = 0;
  logic stray = 1'b0;
  logic pv0 = 1'b0, pv1 = 1'b0;
  logic [15:0] pd0 = '0, pd1 = '0;

  always #5 clock = ~clock;

  lieat_exu_vpu_vseq16 #(.VLEN(VLEN)) dut (
    .clock(clock), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_vadd(i_vadd), .i_vsub(i_vsub), .i_vrsub(i_vrsub),
    .i_vs1(i_vs1), .i_vs2(i_vs2), .i_vd(i_vd), .i_vl(i_vl),
    .vunit_valid(vunit_valid), .vunit_op1(vunit_op1), .vunit_op2(vunit_op2),
    .vunit_vadd(vunit_vadd), .vunit_vsub(vunit_vsub), .vunit_vrsub(vunit_vrsub),
    .vunit_o_valid(vunit_o_valid), .vunit_o_data(vunit_o_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data)
  );

  // Lane arithmetic: op = {add, sub, rsub}; zero-hot yields 0
  function automatic logic [15:0] lane_fn(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [15:0] r;
    r = 16'h0000;
    if (op[2]) r = r | 16'(a + b);
    if (op[1]) r = r | 16'(a - b);
    if (op[0]) r = r | 16'(b - a);
    return r;
  endfunction

  always @(posedge clock) begin
    pv0 <= vunit_valid;
    pd0 <= lane_fn({vunit_vadd, vunit_vsub, vunit_vrsub}, vunit_op1, vunit_op2);
    pv1 <= pv0;
    pd1 <= pd0;
  end

  always_comb begin
    if (stray) begin
      vunit_o_valid = 1'b1;
      vunit_o_data  = 16'hDEAD;
    end else if (lane_delay == 0) begin
      vunit_o_valid = vunit_valid;
      vunit_o_data  = lane_fn({vunit_vadd, vunit_vsub, vunit_vrsub}, vunit_op1, vunit_op2);
    end else begin
      vunit_o_valid = pv1;
      vunit_o_data  = pd1;
    end
  end

  // Full operation: accept, observe issue stream, latency, result, hold and release
  task automatic run_op(input string name, input logic [2:0] op, input logic [VLEN-1:0] a,
                        input logic [VLEN-1:0] b, input logic [VLEN-1:0] d,
                        input logic [VLW-1:0] vl, input int hold, input int dly);
    int vle, issues, lat;
    bit bad_iss, bad_rdy;
    logic [VLEN-1:0] exp;
    vle = (int'(vl) > NELEM) ? NELEM : int'(vl);
    for (int k = 0; k < NELEM; k++)
      exp[k*16 +: 16] = (k < vle) ? lane_fn(op, a[k*16 +: 16], b[k*16 +: 16]) : d[k*16 +: 16];
    lane_delay = dly;
    checks++;
    if (i_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept: got %b want 1", name, i_ready);
    end
    i_valid = 1'b1;
    {i_vadd, i_vsub, i_vrsub} = op;
    i_vs1 = a; i_vs2 = b; i_vd = d; i_vl = vl;
    @(posedge clock); #1;
    i_valid = 1'b0;
    {i_vadd, i_vsub, i_vrsub} = ~op;
    i_vs1 = ~a; i_vs2 = ~b; i_vd = ~d; i_vl = VLW'($urandom);
    issues = 0; lat = -1; bad_iss = 0; bad_rdy = 0;
    for (int n = 0; n < 64; n++) begin
      if (o_valid === 1'b1) begin
        lat = n;
        break;
      end
      if (i_ready !== 1'b0) bad_rdy = 1;
      if (vunit_valid === 1'b1) begin
        if (issues >= NELEM || vunit_op1 !== a[issues*16 +: 16] ||
            vunit_op2 !== b[issues*16 +: 16] || {vunit_vadd, vunit_vsub, vunit_vrsub} !== op)
          bad_iss = 1;
        issues++;
      end
      @(posedge clock); #1;
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL %s timeout: o_valid never seen, want after %0d cycles", name, vle + dly);
      return;
    end
    checks++;
    if (issues != vle) begin
      errors++;
      $display("FAIL %s issue_count: got %0d want %0d", name, issues, vle);
    end
    checks++;
    if (lat != ((vle == 0) ? 0 : vle + dly)) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, (vle == 0) ? 0 : vle + dly);
    end
    checks++;
    if (bad_iss) begin
      errors++;
      $display("FAIL %s issue_operands: got bad element/op on issue want in-order vs1/vs2 %b", name, op);
    end
    checks++;
    if (bad_rdy) begin
      errors++;
      $display("FAIL %s busy_ready: got i_ready=1 while busy want 0", name);
    end
    checks++;
    if (o_data !== exp) begin
      errors++;
      $display("FAIL %s o_data: got %h want %h", name, o_data, exp);
    end
    checks++;
    if ({vunit_valid, vunit_vadd, vunit_vsub, vunit_vrsub} !== 4'b0) begin
      errors++;
      $display("FAIL %s done_vunit_idle: got %b want 0000", name,
               {vunit_valid, vunit_vadd, vunit_vsub, vunit_vrsub});
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp) begin
        errors++;
        $display("FAIL %s hold%0d: got valid=%b data=%h want valid=1 data=%h", name, h,
                 o_valid, o_data, exp);
      end
    end
    o_ready = 1'b1;
    @(posedge clock); #1;
    o_ready = 1'b0;
    checks++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s release: got ready=%b valid=%b want ready=1 valid=0", name, i_ready, o_valid);
    end
    lane_delay = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (i_ready !== 1'b1 || vunit_valid !== 1'b0 || vunit_op1 !== 16'h0 ||
        vunit_op2 !== 16'h0 || {vunit_vadd, vunit_vsub, vunit_vrsub} !== 3'b0 ||
        o_valid !== 1'b0 || o_data !== '0) begin
      errors++;
      $display("FAIL %s: got rdy=%b vv=%b op1=%h op2=%h ops=%b ov=%b od=%h want 1 0 0 0 0 0 0",
               name, i_ready, vunit_valid, vunit_op1, vunit_op2,
               {vunit_vadd, vunit_vsub, vunit_vrsub}, o_valid, o_data);
    end
  endtask

  task automatic test_reset();
    #2;
    check_reset_outputs("reset_held");
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    check_reset_outputs("reset_released");
  endtask

  task automatic test_vadd_basic();
    logic [VLEN-1:0] a, b, d;
    for (int k = 0; k < NELEM; k++) begin
      a[k*16 +: 16] = 16'(k + 1);
      b[k*16 +: 16] = 16'h0010;
      d[k*16 +: 16] = 16'($urandom);
    end
    run_op("vadd_basic", 3'b100, a, b, d, VLW'(8), 0, 0);
  endtask

  task automatic test_vsub_tail();
    logic [VLEN-1:0] a, b, d;
    for (int k = 0; k < NELEM; k++) begin
      a[k*16 +: 16] = 16'h0000;
      b[k*16 +: 16] = 16'h0001;
      d[k*16 +: 16] = 16'hAAAA;
    end
    run_op("vsub_tail", 3'b010, a, b, d, VLW'(3), 0, 0);
  endtask

  task automatic test_vrsub_vl0();
    logic [VLEN-1:0] d;
    d = 128'h0123456789ABCDEF0123456789ABCDEF;
    run_op("vrsub_vl0", 3'b001, {4{32'($urandom)}}, {4{32'($urandom)}}, d, VLW'(0), 0, 0);
  endtask

  task automatic test_clamp_hold();
    run_op("clamp_hold", 3'b100, {4{32'($urandom)}}, {4{32'($urandom)}},
           {4{32'($urandom)}}, VLW'(15), 5, 0);
  endtask

  task automatic test_lane_delay();
    run_op("lane_delay", 3'b010, {4{32'($urandom)}}, {4{32'($urandom)}},
           {4{32'($urandom)}}, VLW'(4), 1, 2);
  endtask

  task automatic test_reset_mid_op();
    logic [VLEN-1:0] a;
    a = {4{32'($urandom)}};
    lane_delay = 0;
    i_valid = 1'b1;
    {i_vadd, i_vsub, i_vrsub} = 3'b100;
    i_vs1 = a; i_vs2 = {4{32'($urandom)}}; i_vd = {4{32'($urandom)}}; i_vl = VLW'(8);
    @(posedge clock); #1;
    i_valid = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    checks++;
    if (vunit_valid !== 1'b1 || vunit_op1 !== a[2*16 +: 16]) begin
      errors++;
      $display("FAIL midop_issue2: got vv=%b op1=%h want 1 %h", vunit_valid, vunit_op1, a[2*16 +: 16]);
    end
    #3 reset = 1'b1;
    #1;
    check_reset_outputs("midop_async_reset");
    @(negedge clock); reset = 1'b0;
    stray = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      checks++;
      if (o_valid !== 1'b0 || i_ready !== 1'b1 || vunit_valid !== 1'b0) begin
        errors++;
        $display("FAIL stray%0d: got ov=%b rdy=%b vv=%b want 0 1 0", c, o_valid, i_ready, vunit_valid);
      end
    end
    stray = 1'b0;
    checks++;
    if (o_data !== '0) begin
      errors++;
      $display("FAIL stray_data: got %h want 0", o_data);
    end
    run_op("after_reset", 3'b010, {4{32'($urandom)}}, {4{32'($urandom)}},
           {4{32'($urandom)}}, VLW'(6), 0, 0);
  endtask

  task automatic test_random();
    logic [2:0] ops [4];
    ops[0] = 3'b100; ops[1] = 3'b010; ops[2] = 3'b001; ops[3] = 3'b000;
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("rand%0d", i), ops[$urandom_range(0, 3)],
             {4{32'($urandom)}}, {4{32'($urandom)}}, {4{32'($urandom)}},
             VLW'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 1) == 1) ? 2 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_vadd_basic();
    test_vsub_tail();
    test_vrsub_vl0();
    test_clamp_hold();
    test_lane_delay();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
